// File: rtl/trdb_packet_arbiter_if.sv
// Requester-side and sink-side stream signals of trdb_packet_arbiter, grouped as one bundle.
// The arbiter uses the master modport and the surrounding producers/sink use the slave modport.
interface trdb_packet_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_last_i;
  logic [NREQ*XLEN-1:0] req_word_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [XLEN-1:0]      packet_word_o;
  logic                 packet_word_valid_o;
  logic                 packet_word_last_o;
  logic                 grant_i;

  modport master (
    input  req_valid_i, req_last_i, req_word_i, grant_i,
    output req_ready_o, packet_word_o, packet_word_valid_o, packet_word_last_o
  );

  modport slave (
    output req_valid_i, req_last_i, req_word_i, grant_i,
    input  req_ready_o, packet_word_o, packet_word_valid_o, packet_word_last_o
  );
endinterface

// File: rtl/trdb_packet_arbiter.sv
// Round-robin packet arbiter: NREQ producers share one trace word stream, packets never interleave,
// one output register stage (1-cycle latency, 1 word/cycle). Optional counters under TRDB_ARB_STATS_EN.
module trdb_packet_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  trdb_packet_arbiter_if.master    bus,
  output logic [$clog2(NREQ)-1:0]  owner_o,
  output logic                     busy_o,
  input  logic                     clear_stats_i,
  output logic [NREQ*CNTW-1:0]     pkt_count_o
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [XLEN-1:0] word_q, word_d;
  logic            last_q, last_d;
  logic            vld_q, vld_d;

  logic            space;
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   sel;
  logic [NREQ-1:0] ready;
  logic            accept;
  logic            acc_last;
  logic [XLEN-1:0] acc_word;

  // Wraps at NREQ-1 so non-power-of-two requester counts never reach unused indices.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && bus.req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign space    = !vld_q || bus.grant_i;
  assign sel      = (state_q == LOCKED) ? owner_q : win_idx;
  assign accept   = |(ready & bus.req_valid_i);
  assign acc_last = bus.req_last_i[sel];
  assign acc_word = bus.req_word_i[sel*XLEN +: XLEN];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ready   = '0;
    case (state_q)
      IDLE:    if (win_found && enable_i && space) ready[win_idx] = 1'b1;
      LOCKED:  if (space) ready[owner_q] = 1'b1;
      default: ;
    endcase
    if (accept) begin
      owner_d = sel;
      if (acc_last) begin
        state_d = IDLE;
        ptr_d   = wrap_inc(sel);
      end else begin
        state_d = LOCKED;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    word_d = word_q;
    last_d = last_q;
    if (accept) begin
      vld_d  = 1'b1;
      word_d = acc_word;
      last_d = acc_last;
    end else if (bus.grant_i) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      word_q  <= word_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.req_ready_o         = ready;
  assign bus.packet_word_o       = word_q;
  assign bus.packet_word_last_o  = last_q;
  assign bus.packet_word_valid_o = vld_q;
  assign owner_o                 = owner_q;
  assign busy_o                  = (state_q == LOCKED);

`ifdef TRDB_ARB_STATS_EN
  logic [CNTW-1:0] cnt_q [NREQ];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else if (clear_stats_i) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else if (accept && acc_last && (cnt_q[sel] != '1)) begin
      cnt_q[sel] <= cnt_q[sel] + 1'b1;
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_cnt
    assign pkt_count_o[k*CNTW +: CNTW] = cnt_q[k];
  end
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats_i;
  assign pkt_count_o        = '0;
`endif
endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Directed bench for trdb_packet_arbiter: per-requester source queues feed the DUT, expected
// output words are queued as stimulus is issued and popped whenever the sink takes a word.
module tb_trdb_packet_arbiter;
  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int CNTW = 2;
`ifdef TRDB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  logic enable_i;
  logic clear_stats_i;
  logic [$clog2(NREQ)-1:0] owner_o;
  logic busy_o;
  logic [NREQ*CNTW-1:0] pkt_count_o;

  trdb_packet_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  trdb_packet_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .bus           (bus),
    .owner_o       (owner_o),
    .busy_o        (busy_o),
    .clear_stats_i (clear_stats_i),
    .pkt_count_o   (pkt_count_o)
  );

  always #5 clk_i = ~clk_i;

  logic [XLEN:0] src0[$];
  logic [XLEN:0] src1[$];
  logic [XLEN:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive();
    bus.req_valid_i[0] = (src0.size() != 0);
    bus.req_last_i[0]  = (src0.size() != 0) ? src0[0][XLEN] : 1'b0;
    bus.req_word_i[0*XLEN +: XLEN] = (src0.size() != 0) ? src0[0][XLEN-1:0] : '0;
    bus.req_valid_i[1] = (src1.size() != 0);
    bus.req_last_i[1]  = (src1.size() != 0) ? src1[0][XLEN] : 1'b0;
    bus.req_word_i[1*XLEN +: XLEN] = (src1.size() != 0) ? src1[0][XLEN-1:0] : '0;
  endtask

  task automatic push(input int r, input logic [XLEN-1:0] w, input logic l, input bit expect_it);
    if (r == 0) src0.push_back({l, w});
    else        src1.push_back({l, w});
    if (expect_it) exp_q.push_back({l, w});
    drive();
  endtask

  // One clock: sample handshakes just before the edge, retire fired items just after it.
  task automatic step();
    logic [NREQ-1:0] fire_in;
    logic            fire_out;
    logic [XLEN:0]   e;
    #1;
    fire_in  = bus.req_valid_i & bus.req_ready_o;
    fire_out = bus.packet_word_valid_o & bus.grant_i;
    if (fire_out) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", 64'(bus.packet_word_o), 64'(e[XLEN-1:0]));
        chk("out_last", 64'(bus.packet_word_last_o), 64'(e[XLEN]));
      end
    end
    @(posedge clk_i);
    #1;
    if (fire_in[0] && src0.size() != 0) void'(src0.pop_front());
    if (fire_in[1] && src1.size() != 0) void'(src1.pop_front());
    drive();
    #1;
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n;
    n = 0;
    while ((src0.size() + src1.size() + exp_q.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(src0.size() + src1.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    enable_i = 1'b1;
    clear_stats_i = 1'b0;
    bus.grant_i = 1'b1;
    bus.req_valid_i = '0;
    bus.req_last_i = '0;
    bus.req_word_i = '0;
    #12;
    chk("rst_valid", 64'(bus.packet_word_valid_o), 64'd0);
    chk("rst_word", 64'(bus.packet_word_o), 64'd0);
    chk("rst_last", 64'(bus.packet_word_last_o), 64'd0);
    chk("rst_owner", 64'(owner_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_count", 64'(pkt_count_o), 64'd0);
    #1 rst_ni = 1'b1;

    // Reset in the middle of a packet from requester 0
    push(0, 32'hA000_0000, 1'b0, 1'b1);
    push(0, 32'hA000_0001, 1'b0, 1'b0);
    push(0, 32'hA000_0002, 1'b1, 1'b0);
    step();
    step();
    chk("mid_busy", 64'(busy_o), 64'd1);
    chk("mid_valid", 64'(bus.packet_word_valid_o), 64'd1);
    rst_ni = 1'b0;
    src0.delete();
    drive();
    #1;
    chk("arst_valid", 64'(bus.packet_word_valid_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_owner", 64'(owner_o), 64'd0);
    #2 rst_ni = 1'b1;
    push(1, 32'hB000_0000, 1'b1, 1'b1);
    #1;
    chk("post_rst_ready", 64'(bus.req_ready_o), 64'b10);
    step();
    chk("post_rst_owner", 64'(owner_o), 64'd1);
    run_until_empty(10, "drain_reset");

    // Round robin with single-word packets, full throughput
    for (int k = 0; k < 4; k++) begin
      push(0, 32'h1000_0000 + k, 1'b1, 1'b0);
      push(1, 32'h2000_0000 + k, 1'b1, 1'b0);
      exp_q.push_back({1'b1, 32'h1000_0000 + k});
      exp_q.push_back({1'b1, 32'h2000_0000 + k});
    end
    for (int k = 0; k < 9; k++) step();
    chk("rr_throughput", 64'(exp_q.size()), 64'd0);
    run_until_empty(10, "drain_rr");

    // Atomicity: requester 1 stays valid while requester 0 sends 4 words
    for (int k = 0; k < 4; k++) push(0, 32'hA100_0000 + k, (k == 3), 1'b1);
    push(1, 32'hB100_0000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_ready", 64'(bus.req_ready_o), 64'b01);
      chk("lock_busy", 64'(busy_o), 64'd1);
    end
    run_until_empty(20, "drain_atomic");

    // Back-pressure holds the output register stable
    push(0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    step();
    bus.grant_i = 1'b0;
    push(1, 32'hC000_0000, 1'b1, 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(bus.packet_word_valid_o), 64'd1);
      chk("bp_word", 64'(bus.packet_word_o), 64'hDEAD_BEEF);
      chk("bp_last", 64'(bus.packet_word_last_o), 64'd1);
      chk("bp_ready", 64'(bus.req_ready_o), 64'b00);
      step();
    end
    bus.grant_i = 1'b1;
    run_until_empty(10, "drain_bp");

    // enable_i low in IDLE blocks new packets
    enable_i = 1'b0;
    push(1, 32'hE100_0000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dis_ready", 64'(bus.req_ready_o), 64'b00);
    end
    chk("dis_pending", 64'(src1.size()), 64'd1);
    chk("dis_valid", 64'(bus.packet_word_valid_o), 64'd0);
    enable_i = 1'b1;
    run_until_empty(10, "drain_en");

    // enable_i dropped mid-packet: packet completes, then nothing new starts
    for (int k = 0; k < 3; k++) push(0, 32'hF000_0000 + k, (k == 2), 1'b1);
    step();
    enable_i = 1'b0;
    push(1, 32'hF100_0000, 1'b1, 1'b1);
    #1;
    chk("en_lock_ready", 64'(bus.req_ready_o), 64'b01);
    for (int k = 0; k < 10 && src0.size() != 0; k++) step();
    chk("en_pkt_done", 64'(src0.size()), 64'd0);
    for (int k = 0; k < 3; k++) step();
    chk("en_no_start", 64'(bus.req_ready_o), 64'b00);
    chk("en_pending", 64'(src1.size()), 64'd1);
    enable_i = 1'b1;
    run_until_empty(10, "drain_en2");

    // Packet counters: saturation and clear-over-increment
    clear_stats_i = 1'b1;
    step();
    clear_stats_i = 1'b0;
    chk("stat_clear", 64'(pkt_count_o), 64'd0);
    for (int k = 0; k < 5; k++) push(0, 32'h5000_0000 + k, 1'b1, 1'b1);
    run_until_empty(20, "drain_stats");
    chk("stat_sat0", 64'(pkt_count_o[0 +: CNTW]), STATS ? 64'd3 : 64'd0);
    chk("stat_cnt1", 64'(pkt_count_o[CNTW +: CNTW]), 64'd0);
    push(1, 32'h6000_0000, 1'b1, 1'b1);
    clear_stats_i = 1'b1;
    step();
    clear_stats_i = 1'b0;
    chk("stat_clear_prio", 64'(pkt_count_o), 64'd0);
    run_until_empty(10, "drain_final");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/trdb_packet_arbiter.md
Name: trdb_packet_arbiter

Overview:
Shares the single trace packet-word output stream (packet_word / packet_word_valid, sink back-pressure via grant) between NREQ packet producers, e.g. several trace encoders or a software-injected packet path.
- Arbitration is round-robin at packet boundaries.
- A multi-word packet is never interleaved with another.
- One output register stage sits between the winner and the sink.
- Sits between the encoder/packer instances and the trace sink/FIFO.

Parameters:
NREQ, 2, number of requesters (2..8)
XLEN, 32, packet word width
CNTW, 16, width of per-requester packet counters (optional feature)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
enable_i  input  1  allow new packets to start
req_valid_i  input  NREQ  requester k has a word
req_last_i  input  NREQ  word of requester k is last of packet
req_word_i  input  NREQ*XLEN  words, requester k at bits [k*XLEN +: XLEN]
req_ready_o  output  NREQ  word of requester k accepted this cycle when valid&ready
packet_word_o  output  XLEN  output word
packet_word_valid_o  output  1  output word valid
packet_word_last_o  output  1  output word ends packet
grant_i  input  1  sink accepts output word this cycle when valid&grant
owner_o  output  $clog2(NREQ)  current/last packet owner
busy_o  output  1  high in LOCKED state
clear_stats_i  input  1  clear packet counters
pkt_count_o  output  NREQ*CNTW  completed packets per requester

Behaviour:
- Reset (async, rst_ni low):
  - packet_word_valid_o=0, packet_word_o=0, packet_word_last_o=0.
  - State IDLE, RR pointer=0, owner_o=0, busy_o=0, counters=0.
- space = !packet_word_valid_o || grant_i.
- IDLE:
  - Winner = first k with req_valid_i[k], searching from the pointer upward with wrap NREQ-1 -> 0.
  - req_ready_o[winner] = space && enable_i; all other ready bits are 0.
  - On accept, owner_o=winner:
    - if req_last_i -> stay IDLE, pointer = (winner+1) mod NREQ;
    - else -> LOCKED.
- LOCKED:
  - req_ready_o[owner] = space; all others 0.
  - enable_i is ignored; the packet always completes.
  - On accepted last word -> IDLE, pointer = (owner+1) mod NREQ.
- req_ready_o is combinational from valid/state/grant_i. No requester-valid-to-ready dependency exists except the winner selection in IDLE.
- Output register:
  - On accept, loads word/last and sets valid=1 at the next edge (1-cycle latency).
  - If valid&grant with no accept -> valid=0.
  - Simultaneous grant and accept in the same cycle -> register replaced, valid stays 1, giving full throughput of 1 word/cycle.
- Output word and last stay stable while valid&&!grant_i.
- A requester dropping valid mid-packet stalls the arbiter in LOCKED; no timeout.
- Single requester only: back-to-back packets at 1 word/cycle, pointer still advances.
- NREQ not a power of two: pointer wraps at NREQ-1, never at 2^n-1.
- enable_i low in IDLE: no ready asserted. The output register still drains.

Optional Feature:
TRDB_ARB_STATS_EN
- Defined:
  - pkt_count_o[k] increments on each accepted last word of requester k.
  - Counters saturate at 2^CNTW-1.
  - clear_stats_i zeroes all counters synchronously and has priority over a same-cycle increment.
- Undefined: pkt_count_o tied to 0, clear_stats_i ignored, no counter flops.

Test Plan:
- Reset mid-packet: req0 sends 3 words, rst_ni pulsed low after word 2 -> valid_o=0 immediately, pointer=0; after release, req1 valid alone is granted first.
- Round robin: both requesters continuously send 1-word packets, grant_i=1 -> output owners alternate 0,1,0,1 with 1 word/cycle.
- Atomicity: req0 sends 4-word packet A0..A3 while req1 is valid throughout -> output A0..A3 contiguous, then req1's word; req_ready_o[1]=0 during the lock.
- Back-pressure: grant_i=0 for 5 cycles with 0xDEADBEEF in the output register -> word/last/valid stable; ready=0; no words lost after grant returns.
- Enable: enable_i=0 while req1 is valid in IDLE -> no accept; enable_i dropped mid-packet of req0 -> packet completes, then no new start.
- Stats (TRDB_ARB_STATS_EN, CNTW=2): 5 packets from req0 -> count saturates at 3; clear_stats_i in the same cycle as a last-word accept -> count reads 0.
